// File: rtl/lc4_trace_if.sv
// -----------------------------------------------------------------------------
// lc4_trace_if
// Beat stream carrying commit-trace records from lc4_trace_capture to a
// host/debug link.
//   valid : beat valid (driven by master)
//   data  : 16-bit beat payload (driven by master)
//   last  : final beat of a record (driven by master)
//   ready : sink accepts beat (driven by slave)
// Handshake: a beat transfers on a rising edge where valid && ready; while
// valid && !ready the master holds data and last stable, and valid is never
// withdrawn before the beat transfers.
// -----------------------------------------------------------------------------
interface lc4_trace_if;
  logic        valid;
  logic [15:0] data;
  logic        last;
  logic        ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/lc4_trace_capture.sv
// -----------------------------------------------------------------------------
// lc4_trace_capture
// Commit-trace generator for lc4_processor. Every processor cycle that
// completes (gwe=1) while i_enable=1 is a sample event. A sample with
// test_stall==0 packs the committed instruction into a record that is queued
// in a DEPTH-record FIFO and streamed out as 16-bit beats. Each sample event
// also bumps the cycle counter selected by test_stall.
//
// Record beat order (BEATS = 4 + 2*WORD_SIZE/16):
//   pc, insn, {rf_we, wsel[2:0], nzp_we, nzp[2:0], dmem_we, 7'b0}, dmem_addr,
//   regfile_data (MS beat first), dmem_data (MS beat first)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   gwe, i_enable       sample qualifiers
//   test_*              lc4_processor commit observation signals
//   trace               beat stream (lc4_trace_if.master)
//   o_overflow          sticky record-dropped flag
//   o_drop_count        dropped records, saturating
//   o_fifo_count        records held (including the one being streamed)
//   o_num_*             per-category cycle counters, wrapping
//
// Build option: define LC4_TRACE_STALL_COUNT_EN to implement the four cycle
// counters; otherwise o_num_* are tied to zero.
// -----------------------------------------------------------------------------
module lc4_trace_capture #(
  parameter int WORD_SIZE = 64,
  parameter int DEPTH     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        gwe,
  input  logic                        i_enable,
  input  logic [1:0]                  test_stall,
  input  logic [15:0]                 test_cur_pc,
  input  logic [15:0]                 test_cur_insn,
  input  logic                        test_regfile_we,
  input  logic [2:0]                  test_regfile_wsel,
  input  logic [WORD_SIZE-1:0]        test_regfile_data,
  input  logic                        test_nzp_we,
  input  logic [2:0]                  test_nzp_new_bits,
  input  logic                        test_dmem_we,
  input  logic [15:0]                 test_dmem_addr,
  input  logic [WORD_SIZE-1:0]        test_dmem_data,
  lc4_trace_if.master                 trace,
  output logic                        o_overflow,
  output logic [15:0]                 o_drop_count,
  output logic [$clog2(DEPTH):0]      o_fifo_count,
  output logic [31:0]                 o_num_exec,
  output logic [31:0]                 o_num_cache_stall,
  output logic [31:0]                 o_num_branch_stall,
  output logic [31:0]                 o_num_load_stall
);

  localparam int BEATS = 4 + 2 * (WORD_SIZE / 16);
  localparam int REC_W = 16 * BEATS;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int BW    = $clog2(BEATS);

  // Records are stored with beat 0 in the most significant 16 bits.
  logic [REC_W-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [15:0]   data_q, data_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_q, drop_d;

  logic             sample;
  logic             capture;
  logic             xfer;
  logic             pop;
  logic             push;
  logic [REC_W-1:0] new_rec;
  logic [REC_W-1:0] head_rec;

  assign sample  = gwe & i_enable;
  assign capture = sample && (test_stall == 2'd0);
  assign xfer    = valid_q & trace.ready;
  assign pop     = xfer & last_q;
  // A full FIFO still accepts a record when its head leaves on this edge.
  assign push    = capture && ((count_q < CW'(DEPTH)) || pop);

  assign new_rec = {test_cur_pc,
                    test_cur_insn,
                    test_regfile_we, test_regfile_wsel,
                    test_nzp_we, test_nzp_new_bits,
                    test_dmem_we, 7'b0,
                    test_dmem_addr,
                    test_regfile_data,
                    test_dmem_data};

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    beat_d     = beat_q;
    if (xfer) begin
      beat_d = last_q ? '0 : beat_q + BW'(1);
    end
    // The output register is loaded from the post-edge FIFO state. When the
    // only record after this edge is the one being pushed, it is not in
    // mem_q yet, so take it straight from the inputs.
    head_rec   = (push && (count_d == CW'(1))) ? new_rec : mem_q[rd_ptr_d];
    valid_d    = (count_d != '0);
    data_d     = data_q;
    last_d     = 1'b0;
    if (valid_d) begin
      data_d = head_rec[(BEATS - 1 - int'(beat_d)) * 16 +: 16];
      last_d = (beat_d == BW'(BEATS - 1));
    end
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (capture && !push) begin
      overflow_d = 1'b1;
      if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= new_rec;
    end
  end

  assign trace.valid  = valid_q;
  assign trace.data   = data_q;
  assign trace.last   = last_q;
  assign o_overflow   = overflow_q;
  assign o_drop_count = drop_q;
  assign o_fifo_count = count_q;

`ifdef LC4_TRACE_STALL_COUNT_EN
  // Indexed by test_stall: 0=exec, 1=cache, 2=branch, 3=load.
  logic [31:0] cnt_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (sample) begin
      cnt_q[test_stall] <= cnt_q[test_stall] + 32'd1;
    end
  end

  assign o_num_exec         = cnt_q[0];
  assign o_num_cache_stall  = cnt_q[1];
  assign o_num_branch_stall = cnt_q[2];
  assign o_num_load_stall   = cnt_q[3];
`else
  assign o_num_exec         = '0;
  assign o_num_cache_stall  = '0;
  assign o_num_branch_stall = '0;
  assign o_num_load_stall   = '0;
`endif

endmodule
